// File: rtl/lcd_text_buffer_if.sv
// Purpose: bundles the cell-write port and the byte stream towards the
//   LCD1602 controller for lcd_text_buffer.
// Signals:
//   wr_en, wr_row, wr_col, wr_char  cell write strobe and target/data
//   clear                           blank-fill request (pulse)
//   out_valid, out_ready            byte stream handshake
//   out_rs, out_data                0 = command, 1 = character; byte value
// Modports: master = game/UI logic plus controller side, slave = the buffer.
interface lcd_text_buffer_if;
  logic       wr_en;
  logic       wr_row;
  logic [3:0] wr_col;
  logic [7:0] wr_char;
  logic       clear;
  logic       out_valid;
  logic       out_ready;
  logic       out_rs;
  logic [7:0] out_data;

  modport master (
    output wr_en, wr_row, wr_col, wr_char, clear, out_ready,
    input  out_valid, out_rs, out_data
  );

  modport slave (
    input  wr_en, wr_row, wr_col, wr_char, clear, out_ready,
    output out_valid, out_rs, out_data
  );
endinterface

// File: rtl/lcd_text_buffer.sv
// Purpose: 2x16 character frame buffer feeding the LCD1602 controller.
//   Cells are written at (row,col); whole frames (address command + 16
//   characters per line, 34 beats) are streamed whenever the buffer is
//   dirty, with an enforced idle gap between frames.
// Ports:
//   clk    system clock, rising edge
//   reset  asynchronous active-low reset
//   bus    slave side of lcd_text_buffer_if (write port + byte stream)
//   busy   high whenever the FSM is not in IDLE
//
// state | meaning
// ------+---------------------------------------------------------------
// CLEAR | blank-fill cells 0..31, one per cycle; writes dropped
// IDLE  | wait for clear request or dirty buffer
// ADDR0 | presenting LINE0_CMD (rs=0)
// CHAR0 | presenting row 0 cell col (rs=1)
// ADDR1 | presenting LINE1_CMD (rs=0)
// CHAR1 | presenting row 1 cell col (rs=1)
// GAP   | REFRESH_GAP idle cycles after a frame
module lcd_text_buffer #(
  parameter int unsigned REFRESH_GAP = 1000,
  parameter logic [7:0]  BLANK_CHAR  = 8'h20,
  parameter logic [7:0]  LINE0_CMD   = 8'h80,
  parameter logic [7:0]  LINE1_CMD   = 8'hC0
) (
  input  logic             clk,
  input  logic             reset,
  lcd_text_buffer_if.slave bus,
  output logic             busy
);

  localparam int unsigned GAP_W = (REFRESH_GAP > 1) ? $clog2(REFRESH_GAP) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = GAP_W'(REFRESH_GAP - 1);

  typedef enum logic [2:0] {
    S_CLEAR, S_IDLE, S_ADDR0, S_CHAR0, S_ADDR1, S_CHAR1, S_GAP
  } state_t;

  state_t           state, state_n;
  logic [3:0]       col, col_n, col_inc;
  logic [4:0]       clr_idx, clr_idx_n;
  logic [GAP_W-1:0] gap_cnt, gap_cnt_n;
  logic             dirty, dirty_n;
  logic             clear_pend, clear_pend_n;
  logic             valid_q, valid_n;
  logic             rs_q, rs_n;
  logic [7:0]       data_q, data_n;
  logic             xfer;

  logic [7:0] mem [0:31];

  assign bus.out_valid = valid_q;
  assign bus.out_rs    = rs_q;
  assign bus.out_data  = data_q;
  assign busy          = (state != S_IDLE);
  assign xfer          = valid_q && bus.out_ready;
  assign col_inc       = col + 4'd1;

  // Cell storage needs no reset: the FSM comes out of reset in CLEAR.
  always_ff @(posedge clk) begin
    if (state == S_CLEAR) begin
      mem[clr_idx] <= BLANK_CHAR;
    end else if (bus.wr_en) begin
      mem[{bus.wr_row, bus.wr_col}] <= bus.wr_char;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= S_CLEAR;
      col        <= 4'd0;
      clr_idx    <= 5'd0;
      gap_cnt    <= '0;
      dirty      <= 1'b0;
      clear_pend <= 1'b0;
      valid_q    <= 1'b0;
      rs_q       <= 1'b0;
      data_q     <= 8'h00;
    end else begin
      state      <= state_n;
      col        <= col_n;
      clr_idx    <= clr_idx_n;
      gap_cnt    <= gap_cnt_n;
      dirty      <= dirty_n;
      clear_pend <= clear_pend_n;
      valid_q    <= valid_n;
      rs_q       <= rs_n;
      data_q     <= data_n;
    end
  end

  // The next byte is fetched from the cell array only when the current one
  // transfers, so a stalled byte stays stable even if its cell is rewritten.
  always_comb begin
    state_n      = state;
    col_n        = col;
    clr_idx_n    = clr_idx;
    gap_cnt_n    = gap_cnt;
    dirty_n      = dirty;
    clear_pend_n = clear_pend;
    valid_n      = valid_q;
    rs_n         = rs_q;
    data_n       = data_q;

    case (state)
      S_CLEAR: begin
        clr_idx_n = clr_idx + 5'd1;
        if (clr_idx == 5'd31) begin
          state_n = S_IDLE;
          dirty_n = 1'b1;
        end
      end
      S_IDLE: begin
        if (clear_pend || bus.clear) begin
          state_n      = S_CLEAR;
          clear_pend_n = 1'b0;
          clr_idx_n    = 5'd0;
        end else if (dirty) begin
          state_n = S_ADDR0;
          dirty_n = 1'b0;
          valid_n = 1'b1;
          rs_n    = 1'b0;
          data_n  = LINE0_CMD;
        end
      end
      S_ADDR0: begin
        if (xfer) begin
          state_n = S_CHAR0;
          col_n   = 4'd0;
          rs_n    = 1'b1;
          data_n  = mem[5'd0];
        end
      end
      S_CHAR0: begin
        if (xfer) begin
          if (col == 4'd15) begin
            state_n = S_ADDR1;
            rs_n    = 1'b0;
            data_n  = LINE1_CMD;
          end else begin
            col_n  = col_inc;
            data_n = mem[{1'b0, col_inc}];
          end
        end
      end
      S_ADDR1: begin
        if (xfer) begin
          state_n = S_CHAR1;
          col_n   = 4'd0;
          rs_n    = 1'b1;
          data_n  = mem[5'd16];
        end
      end
      S_CHAR1: begin
        if (xfer) begin
          if (col == 4'd15) begin
            state_n   = S_GAP;
            valid_n   = 1'b0;
            rs_n      = 1'b0;
            data_n    = 8'h00;
            gap_cnt_n = GAP_LOAD;
          end else begin
            col_n  = col_inc;
            data_n = mem[{1'b1, col_inc}];
          end
        end
      end
      S_GAP: begin
        if (gap_cnt == '0) begin
          state_n = S_IDLE;
        end else begin
          gap_cnt_n = gap_cnt - 1'b1;
        end
      end
      default: state_n = S_IDLE;
    endcase

    // A clear arriving mid-frame waits for the next IDLE; during CLEAR it
    // is redundant and dropped.
    if (bus.clear && state != S_IDLE && state != S_CLEAR) begin
      clear_pend_n = 1'b1;
    end

    // Placed last so a write in the IDLE->ADDR0 cycle keeps dirty set.
    if (bus.wr_en && state != S_CLEAR) begin
      dirty_n = 1'b1;
    end
  end

endmodule

// File: tb/tb_lcd_text_buffer.sv
// Directed bench for lcd_text_buffer with REFRESH_GAP=8.
// Frame timing reference: after the last beat transfers, GAP runs 8 cycles
// and IDLE takes one decision cycle, so the next first beat appears
// REFRESH_GAP+2 cycles after the previous last beat was seen.
module tb_lcd_text_buffer;
  localparam int GAP = 8;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic busy;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;

  lcd_text_buffer_if bus();

  lcd_text_buffer #(.REFRESH_GAP(GAP)) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus),
    .busy (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  typedef struct {
    logic       row;
    logic [3:0] col;
    logic [7:0] ch;
    int         beat;
  } wvec_t;

  wvec_t      tbl [4];
  logic [7:0] mdl [32];
  logic [8:0] fr  [34];
  int first_wait, first_cyc, last_cyc;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [8:0] exp_beat(input int i);
    if (i == 0)  return {1'b0, 8'h80};
    if (i <= 16) return {1'b1, mdl[i-1]};
    if (i == 17) return {1'b0, 8'hC0};
    return {1'b1, mdl[i-2]};
  endfunction

  task automatic check_frame(input string name);
    for (int i = 0; i < 34; i++)
      chk($sformatf("%s beat%0d", name, i), 32'(fr[i]), 32'(exp_beat(i)));
  endtask

  task automatic blank_model();
    for (int i = 0; i < 32; i++) mdl[i] = 8'h20;
  endtask

  // Collects one 34-beat frame. Optionally stalls beat stall_at for
  // stall_len cycles and fires a write (act=1) or clear (act=2) on the
  // cycle beat act_at is presented.
  task automatic get_frame(input int stall_at, input int stall_len, input int act,
                           input int act_at, input logic act_row,
                           input logic [3:0] act_col, input logic [7:0] act_ch);
    int n = 0;
    int waitc = 0;
    int st = 0;
    bit acted = 0;
    bit dropped = 0;
    bit moved = 0;
    logic [8:0] held = '0;
    first_wait = -1;
    while (n < 34) begin
      @(negedge clk);
      waitc++;
      bus.wr_en = 1'b0;
      bus.clear = 1'b0;
      if (waitc > 3000) begin
        chk("frame_timeout beats", 32'(n), 32'd34);
        return;
      end
      if (!bus.out_valid) begin
        if (n > 0) dropped = 1;
        bus.out_ready = 1'b1;
      end else begin
        if (n == 0 && first_wait < 0) begin
          first_wait = waitc;
          first_cyc  = cyc;
        end
        if (act != 0 && !acted && n == act_at) begin
          acted = 1;
          if (act == 1) begin
            bus.wr_en   = 1'b1;
            bus.wr_row  = act_row;
            bus.wr_col  = act_col;
            bus.wr_char = act_ch;
          end else begin
            bus.clear = 1'b1;
          end
        end
        if (n == stall_at && st < stall_len) begin
          if (st == 0) held = {bus.out_rs, bus.out_data};
          else if ({bus.out_rs, bus.out_data} !== held) moved = 1;
          st++;
          bus.out_ready = 1'b0;
        end else begin
          if (n == stall_at && stall_len > 0 && {bus.out_rs, bus.out_data} !== held) moved = 1;
          bus.out_ready = 1'b1;
          fr[n] = {bus.out_rs, bus.out_data};
          n++;
          if (n == 34) last_cyc = cyc;
        end
      end
    end
    chk("valid_held_mid_frame", 32'(dropped), 32'd0);
    if (stall_len > 0) chk("stall_stable", 32'(moved), 32'd0);
  endtask

  task automatic frame_plain();
    get_frame(-1, 0, 0, 0, 1'b0, 4'd0, 8'd0);
  endtask

  task automatic do_write(input logic r, input logic [3:0] c, input logic [7:0] ch, input logic clr);
    @(negedge clk);
    bus.wr_en   = 1'b1;
    bus.wr_row  = r;
    bus.wr_col  = c;
    bus.wr_char = ch;
    bus.clear   = clr;
    @(negedge clk);
    bus.wr_en = 1'b0;
    bus.clear = 1'b0;
  endtask

  task automatic expect_quiet(input int ncyc);
    bit seen = 0;
    repeat (ncyc) begin
      @(negedge clk);
      if (bus.out_valid) seen = 1;
    end
    chk("no_extra_frame", 32'(seen), 32'd0);
  endtask

  task automatic wait_idle();
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (busy && k < 300);
    chk("reach_idle busy", 32'(busy), 32'd0);
  endtask

  initial begin
    int L;
    int n;
    int k;

    tbl[0] = '{1'b0, 4'd0,  8'h48, 1};
    tbl[1] = '{1'b1, 4'd15, 8'h41, 33};
    tbl[2] = '{1'b0, 4'd9,  8'h4C, 10};
    tbl[3] = '{1'b1, 4'd3,  8'h33, 21};

    bus.wr_en = 1'b0; bus.wr_row = 1'b0; bus.wr_col = 4'd0; bus.wr_char = 8'd0;
    bus.clear = 1'b0; bus.out_ready = 1'b1;
    blank_model();

    // Reset values
    repeat (3) @(negedge clk);
    chk("rst out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst out_rs",    32'(bus.out_rs),    32'd0);
    chk("rst out_data",  32'(bus.out_data),  32'h00);
    chk("rst busy",      32'(busy),          32'd1);

    // 1: blank frame after 32 clear cycles + 1 decision cycle
    reset = 1'b1;
    frame_plain();
    chk("startup first_beat_wait", 32'(first_wait), 32'd33);
    check_frame("blank");
    expect_quiet(40);
    chk("idle_after_gap busy", 32'(busy), 32'd0);

    // 2: table writes, held off with out_ready=0 until all are in
    @(negedge clk);
    bus.out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.wr_en   = 1'b1;
      bus.wr_row  = tbl[i].row;
      bus.wr_col  = tbl[i].col;
      bus.wr_char = tbl[i].ch;
      mdl[{tbl[i].row, tbl[i].col}] = tbl[i].ch;
    end
    @(negedge clk);
    bus.wr_en = 1'b0;
    frame_plain();
    check_frame("writes");
    for (int i = 0; i < 4; i++)
      chk($sformatf("table vec%0d", i), 32'(fr[tbl[i].beat]), 32'({1'b1, tbl[i].ch}));
    L = last_cyc;
    // later writes landed in the IDLE->ADDR0 cycle or after: another frame
    frame_plain();
    check_frame("set_wins_repeat");
    chk("frame_gap", 32'(first_cyc - L), 32'(GAP + 2));

    // 3: stall on beat 5 while its cell is rewritten
    wait_idle();
    do_write(1'b0, 4'd4, 8'h35, 1'b0);
    mdl[4] = 8'h35;
    get_frame(5, 5, 1, 5, 1'b0, 4'd4, 8'h36);
    check_frame("stall");
    mdl[4] = 8'h36;

    // 4: write to an already-sent cell mid-frame
    get_frame(-1, 0, 1, 4, 1'b0, 4'd2, 8'h37);
    check_frame("midwrite_old");
    L = last_cyc;
    mdl[2] = 8'h37;
    frame_plain();
    check_frame("midwrite_new");
    chk("midwrite_gap", 32'(first_cyc - L), 32'(GAP + 2));
    expect_quiet(30);

    // 5: clear at beat 10 -> frame unchanged, gap, CLEAR, blank frame
    wait_idle();
    do_write(1'b1, 4'd8, 8'h5A, 1'b0);
    mdl[24] = 8'h5A;
    get_frame(-1, 0, 2, 10, 1'b0, 4'd0, 8'd0);
    check_frame("clear_pending");
    L = last_cyc;
    blank_model();
    frame_plain();
    check_frame("after_clear");
    chk("clear_gap", 32'(first_cyc - L), 32'(GAP + 2 + 33));
    expect_quiet(30);

    // write and clear together in IDLE: write is lost
    wait_idle();
    do_write(1'b0, 4'd0, 8'h51, 1'b1);
    frame_plain();
    chk("wr_clear first_beat_wait", 32'(first_wait), 32'd33);
    check_frame("wr_clear_same_cycle");
    expect_quiet(30);

    // 6: reset at beat 20
    wait_idle();
    do_write(1'b0, 4'd1, 8'h52, 1'b0);
    n = 0;
    k = 0;
    while (n < 20 && k < 500) begin
      @(negedge clk);
      k++;
      if (bus.out_valid) n++;
    end
    chk("partial beats", 32'(n), 32'd20);
    @(negedge clk);
    chk("valid_before_reset", 32'(bus.out_valid), 32'd1);
    reset = 1'b0;
    #1;
    chk("midrst out_valid", 32'(bus.out_valid), 32'd0);
    chk("midrst out_rs",    32'(bus.out_rs),    32'd0);
    chk("midrst out_data",  32'(bus.out_data),  32'h00);
    chk("midrst busy",      32'(busy),          32'd1);
    repeat (3) @(negedge clk);
    reset = 1'b1;
    blank_model();
    frame_plain();
    chk("post_reset first_beat_wait", 32'(first_wait), 32'd33);
    check_frame("post_reset");
    expect_quiet(20);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
